// File: rtl/add_seq_wide.sv
// Multi-word sequential adder: one 128-bit prefix adder, NWORDS passes.
// Optional subtract support is enabled by defining ADD_SEQ_SUB_EN.
module HC_128_BK0_KS7 (
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic         cin,
    output logic [127:0] sum,
    output logic         cout
);
    logic [127:0] gg [0:7];
    logic [127:0] pp [0:7];

    // cin is folded into bit-0 generate so the prefix tree carries it
    always_comb begin
        pp[0] = a ^ b;
        gg[0] = (a & b) | {127'd0, pp[0][0] & cin};
        for (int l = 0; l < 7; l++) begin
            for (int i = 0; i < 128; i++) begin
                if (i >= (1 << l)) begin
                    gg[l+1][i] = gg[l][i]
                               | (pp[l][i] & gg[l][i-(1<<l)]);
                    pp[l+1][i] = pp[l][i] & pp[l][i-(1<<l)];
                end else begin
                    gg[l+1][i] = gg[l][i];
                    pp[l+1][i] = pp[l][i];
                end
            end
        end
    end

    assign sum  = pp[0] ^ {gg[7][126:0], cin};
    assign cout = gg[7][127];
endmodule

module add_seq_wide #(
    parameter int NWORDS = 4,
    localparam int W = 128 * NWORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy
);
    localparam int KW = $clog2(NWORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [KW-1:0] k;
    logic          carry;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  b_eff;
    logic          cin_eff;
    logic [127:0]  aw;
    logic [127:0]  bw;
    logic [127:0]  add_sum;
    logic          add_cout;
    logic          last;

`ifdef ADD_SEQ_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    always_comb begin
        aw = '0;
        bw = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (k == KW'(i)) begin
                aw = a_q[i*128 +: 128];
                bw = b_q[i*128 +: 128];
            end
        end
    end

    HC_128_BK0_KS7 u_add (
        .a    (aw),
        .b    (bw),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign last = (k == KW'(NWORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b_eff;
                        carry <= cin_eff;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NWORDS; i++) begin
                        if (k == KW'(i))
                            sum[i*128 +: 128] <= add_sum;
                    end
                    carry <= add_cout;
                    k     <= k + KW'(1);
                    if (last) begin
                        cout  <= add_cout;
                        ovf   <= (a_q[W-1] == b_q[W-1])
                              && (add_sum[127] != a_q[W-1]);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
endmodule

// File: doc/add_seq_wide.md
ADD_SEQ_WIDE -- requirements
Module: add_seq_wide

Interface
REQ-001 The block SHALL take parameter NWORDS, default 4, meaning the number of 128-bit words per operand (2..8); operand width W = 128*NWORDS.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port a, input, W bits: operand A.
REQ-007 The block SHALL have port b, input, W bits: operand B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in into word 0.
REQ-009 The block SHALL have port sub, input, 1 bit: subtract request; the port is present only with SUB_EN.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result held.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 The block SHALL have port sum, output, W bits: result.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of bit W-1.
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement overflow of the W-bit result.
REQ-015 The block SHALL have port busy, output, 1 bit: high in RUN.

Function
REQ-016 The block SHALL instantiate exactly one HC_128_BK0_KS7 and compute the W-bit sum in NWORDS passes through it, least-significant word first.
REQ-017 FSM states SHALL be IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==RUN).
REQ-018 In IDLE, when in_valid is high: capture a, b, cin and sub into registers, clear the word counter k to 0, load the carry register with the effective carry-in, and go to RUN.
REQ-019 In RUN, each cycle: apply captured word k with the carry register to the adder; write the adder sum into sum[128k+127:128k]; load the carry register with the adder cout; increment k.
REQ-020 When k==NWORDS-1 in RUN: perform that cycle's update, then go to DONE; latency from the accept edge to out_valid high SHALL be exactly NWORDS cycles.
REQ-021 cout SHALL equal the adder carry from word NWORDS-1.
REQ-022 ovf SHALL equal (A[W-1]==B'[W-1]) && (sum[W-1]!=A[W-1]), where B' is the effective B operand.
REQ-023 In DONE: sum, cout and ovf SHALL hold stable; out_valid&&out_ready returns the FSM to IDLE on that edge.
REQ-024 A new request SHALL never be accepted in the same cycle a result is released; minimum request spacing is NWORDS+2 cycles.
REQ-025 Input changes on a, b, cin and sub outside the accept cycle SHALL have no effect on the result.
REQ-026 sum words not yet written in RUN SHALL keep their previous values; only the DONE contents are defined.
REQ-027 Carry wrap-around: the carry register SHALL chain every word boundary, including full propagation across all W bits.

Reset
REQ-028 While rst is high at a clock edge: state SHALL become IDLE, k=0, carry register 0, sum=0, cout=0, ovf=0; hence out_valid=0, busy=0 and in_ready=1 after the edge.
REQ-029 A reset asserted in RUN or DONE SHALL discard the operation with no partial output valid; rst has priority over in_valid and out_ready.

Configuration
REQ-030 With macro ADD_SEQ_SUB_EN defined: the sub port SHALL exist; on accept with sub=1, the block SHALL capture B' = ~b, effective carry-in = 1 and ignore cin, yielding a-b with cout=1 meaning no borrow; with sub=0 it SHALL behave as add.
REQ-031 Without ADD_SEQ_SUB_EN: the sub port SHALL be absent, B'=b, effective carry-in = cin, and no inverter logic SHALL be present.

Verification
REQ-032 Bench SHALL cover: NWORDS=4, a=2^512-1, b=0, cin=1 -> after 4 cycles sum=0, cout=1, ovf=0.
REQ-033 Bench SHALL cover: a=0x7FFF...F (W bits), b=1, cin=0 -> sum=0x8000...0, cout=0, ovf=1.
REQ-034 Bench SHALL cover: result ready with out_ready held 0 for 10 cycles -> out_valid and sum stable, in_ready=0, then release on out_ready=1 and in_ready=1 next cycle.
REQ-035 Bench SHALL cover: rst pulsed in the 2nd RUN cycle -> next cycle IDLE, sum=0, out_valid=0; a following request a=5, b=7 yields sum=12.
REQ-036 Bench SHALL cover, with ADD_SEQ_SUB_EN: a=3, b=5, sub=1 -> sum=2^W-2, cout=0; a=5, b=3, sub=1 -> sum=2, cout=1.
REQ-037 Bench SHALL cover: 1000 random back-to-back requests with random out_ready -> results match reference W-bit arithmetic and are never lost or duplicated.
